// File: rtl/fare_accum_if.sv
// Bus between the taximeter configuration stage (master) and the fare
// accumulator (slave): per-unit increments in, running distance/fare out.
interface fare_accum_if;
  // Handshake: tick is the only strobe. add_len/add_cost are sampled on the
  // edge that closes a tick=1 cycle and must be stable there; there is no
  // valid/ready pair and no backpressure, the slave paces the master.
  logic        conf;
  logic        clear;
  logic [11:0] init_cost;
  logic        add_len;
  logic [11:0] add_cost;
  logic        tick;
  logic [11:0] new_len;
  logic [11:0] new_cost;
  logic        ovf;

  modport master (
    output conf, clear, init_cost, add_len, add_cost,
    input  tick, new_len, new_cost, ovf
  );

  modport slave (
    input  conf, clear, init_cost, add_len, add_cost,
    output tick, new_len, new_cost, ovf
  );
endinterface

// File: rtl/fare_accum.sv
// Running distance/fare accumulator (3-digit packed BCD) with the distance-tick
// prescaler. Optional macro FARE_SAT_EN: clamp at 999 and freeze instead of wrapping.
module fare_accum #(
  parameter int          TICK_DIV  = 50,
  parameter logic [11:0] INIT_COST = 12'h009
) (
  input  logic        clk,
  input  logic        reset,
  fare_accum_if.slave bus,
  output logic [1:0]  state_dbg
);

`ifdef FARE_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  localparam logic [11:0] CNT_MAX = 12'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_SAT  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [11:0] cnt;
  logic [12:0] len_sum;
  logic [12:0] cost_sum;
  logic        any_ovf;
  logic        do_add;
  logic        cnt_en;
  logic        cnt_wrap;
  logic        tick_nxt;

  // Digit-serial BCD add with +6 correction; bit 12 is the carry out of digit 2.
  function automatic logic [12:0] bcd_add(input logic [11:0] a, input logic [11:0] b);
    logic [4:0]  s;
    logic        c;
    logic [11:0] r;
    c = 1'b0;
    r = '0;
    for (int d = 0; d < 3; d++) begin
      s = {1'b0, a[d*4 +: 4]} + {1'b0, b[d*4 +: 4]} + {4'd0, c};
      if (s > 5'd9) begin
        s = s + 5'd6;
        c = 1'b1;
      end else begin
        c = 1'b0;
      end
      r[d*4 +: 4] = s[3:0];
    end
    return {c, r};
  endfunction

  assign len_sum   = bcd_add(bus.new_len, {11'd0, bus.add_len});
  assign cost_sum  = bcd_add(bus.new_cost, bus.add_cost);
  assign any_ovf   = len_sum[12] | cost_sum[12];
  assign state_dbg = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.clear) begin
      state_nxt = bus.conf ? S_RUN : S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (bus.conf) state_nxt = S_RUN;
        // An overflowing tick locks into SAT even if conf drops in the same cycle.
        S_RUN: begin
          if (SAT_EN && bus.tick && any_ovf) state_nxt = S_SAT;
          else if (!bus.conf)                state_nxt = S_IDLE;
        end
        S_SAT:   state_nxt = S_SAT;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    do_add   = bus.tick && (state == S_RUN) && !bus.clear;
    cnt_en   = ((state == S_RUN) && bus.conf) || (state == S_SAT);
    cnt_wrap = (cnt == CNT_MAX);
    tick_nxt = cnt_en && cnt_wrap && !bus.clear;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt          <= '0;
      bus.tick     <= 1'b0;
      bus.new_len  <= 12'h000;
      bus.new_cost <= INIT_COST;
      bus.ovf      <= 1'b0;
    end else if (bus.clear) begin
      cnt          <= '0;
      bus.tick     <= 1'b0;
      bus.new_len  <= 12'h000;
      bus.new_cost <= bus.init_cost;
      bus.ovf      <= 1'b0;
    end else begin
      bus.tick <= tick_nxt;
      cnt      <= (!cnt_en || cnt_wrap) ? 12'd0 : cnt + 12'd1;
      if (do_add) begin
        // Each register clamps independently; the non-overflowing one still adds.
        bus.new_len  <= (SAT_EN && len_sum[12])  ? 12'h999 : len_sum[11:0];
        bus.new_cost <= (SAT_EN && cost_sum[12]) ? 12'h999 : cost_sum[11:0];
        if (any_ovf) bus.ovf <= 1'b1;
      end
    end
  end

endmodule

// File: doc/fare_accum.md
# fare_accum

Downstream accumulation stage of the taximeter datapath. Consumes the per-unit increments (`add_len`, `add_cost`) produced by the configuration/initialisation stage. Maintains the running distance and fare as 3-digit packed BCD. Feeds `new_len` and `new_cost` back to that stage every cycle. Owns the distance-tick prescaler that paces all metering.

## Interface

Parameters:
- `TICK_DIV`, default 50: clk cycles per distance/time unit. Legal range 2..4095.
- `INIT_COST`, default 12'h009: fare loaded on reset (BCD).

Ports:
- `clk`  in  1: system clock, rising edge.
- `reset`  in  1: asynchronous, active-low.
- `conf`  in  1: 1 = metering run; 0 = configuration/idle.
- `clear`  in  1: synchronous trip clear; high for one or more cycles.
- `init_cost`  in  12: BCD fare loaded on `clear`.
- `add_len`  in  1: add one distance unit on the next tick.
- `add_cost`  in  12: BCD fare increment applied on the next tick.
- `tick`  out  1: one-cycle pulse per unit, registered.
- `new_len`  out  12: accumulated distance, BCD 000–999.
- `new_cost`  out  12: accumulated fare, BCD 000–999.
- `ovf`  out  1: sticky overflow flag.

## Operation

- **States:** IDLE, RUN, SAT. Encoding is free.
- **IDLE:**
  - Entered on reset.
  - Left for RUN when `conf`=1 and `clear`=0.
  - Prescaler is held at 0 and `tick`=0.
  - `new_len`/`new_cost` hold their values.
- **RUN:**
  - Prescaler counts 0..TICK_DIV-1.
  - `tick`=1 in the cycle after the count reaches TICK_DIV-1; the count then returns to 0.
  - On each cycle with `tick`=1:
    - `new_len` += `add_len` (BCD).
    - `new_cost` += `add_cost` (BCD).
  - `conf`=0 returns to IDLE and resets the prescaler.
- **SAT:**
  - Entered only when FARE_SAT_EN is defined and a sum exceeds 999.
  - Both registers freeze. Ticks are still generated but ignored.
  - Left only by `clear` or reset.
- **clear:**
  - Has priority over everything except reset, in any state.
  - Sets `new_len`=000, `new_cost`=`init_cost`, `ovf`=0, prescaler=0.
  - Next state: IDLE if `conf`=0, RUN if `conf`=1.
- **BCD arithmetic:**
  - Per-digit add with +6 correction and carry ripple across 3 digits.
  - Carry out of digit 2 is the overflow condition.
  - Non-BCD digits (>9) on inputs give unspecified sums and are not checked.
- **Overflow:**
  - `ovf` sets on the tick whose sum carries out.
  - It stays set until `clear` or reset.
- **Simultaneous events:**
  - `clear` with `tick`: clear wins and no add occurs.
  - `conf` falling with `tick`: the add is performed and the state goes to IDLE.
  - `add_len`=0 with `add_cost`≠0 on a tick (waiting time): only the fare advances.

## Timing

- Reset values: `new_len`=000, `new_cost`=INIT_COST, `tick`=0, `ovf`=0, state IDLE, prescaler 0.
- First `tick` comes TICK_DIV cycles after the first RUN cycle.
- Add latency is 1 cycle: increments sampled on the edge where `tick`=1 appear on `new_*` after that edge.
- Upstream sees updated values one cycle later, because it registers `new_*`.
- `add_len`/`add_cost` must be stable on the sampling edge. No handshake beyond `tick`.
- Reset mid-trip aborts immediately (asynchronous). Outputs return to their reset values within the same cycle.

## Configuration

- `FARE_SAT_EN`:
  - Defined: a sum >999 clamps the affected register(s) to 999, sets `ovf`, and enters SAT.
  - Undefined: sums wrap modulo 1000 (carry discarded), `ovf` sets sticky, and the state stays RUN.

## Test plan

- Reset, TICK_DIV=4 → `new_len`=000, `new_cost`=009, `ovf`=0. Raise `conf` → first `tick` 4 cycles later, then every 4 cycles.
- RUN with `add_len`=1, `add_cost`=003, from 009 → after ticks 1, 2, 3: cost 012, 015, 018 and len 001, 002, 003.
- BCD carry: `new_cost`=098, `add_cost`=005 → 103. Then `new_len`=099 plus one unit → 100.
- Overflow: cost 997 + 005.
  - FARE_SAT_EN defined: 999, `ovf`=1, further ticks leave the value unchanged.
  - FARE_SAT_EN undefined: 002, `ovf`=1, counting continues.
- Pause (waiting time): `add_len`=0, `add_cost`=002 → len constant, cost +2 per tick. `clear` coincident with `tick`, `init_cost`=012 → len 000, cost 012, no add.
- Async reset asserted mid-prescale → outputs at reset values before the next edge. `tick` stays 0 until TICK_DIV cycles after re-entering RUN.
